// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine change-return path:
// coin-select codes, change FSM state encodings and default coin values.
package vending_pkg;

  localparam logic [1:0] COIN_NICKEL  = 2'd0;
  localparam logic [1:0] COIN_DIME    = 2'd1;
  localparam logic [1:0] COIN_QUARTER = 2'd2;

  localparam logic [1:0] CHG_IDLE = 2'd0;
  localparam logic [1:0] CHG_SEL  = 2'd1;
  localparam logic [1:0] CHG_REQ  = 2'd2;
  localparam logic [1:0] CHG_DONE = 2'd3;

  localparam int DEF_QUARTER = 25;
  localparam int DEF_DIME    = 10;
  localparam int DEF_NICKEL  = 5;

endpackage

// File: rtl/change_dp.sv
// Change datapath: remaining-credit register with load/subtract and the
// coin-threshold comparators that steer the greedy payout FSM.
module change_dp
  import vending_pkg::*;
#(
  parameter int W       = 8,
  parameter int QUARTER = DEF_QUARTER,
  parameter int DIME    = DEF_DIME,
  parameter int NICKEL  = DEF_NICKEL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sub,
  input  logic [1:0]   sel,
  input  logic [W-1:0] amount,
  output logic         ge_q,
  output logic         ge_d,
  output logic         ge_n,
  output logic         rem_zero
);

  localparam logic [W-1:0] Q_V = W'(QUARTER);
  localparam logic [W-1:0] D_V = W'(DIME);
  localparam logic [W-1:0] N_V = W'(NICKEL);

  logic [W-1:0] rem;
  logic [W-1:0] coin_val;

  always_comb begin
    coin_val = N_V;
    case (sel)
      COIN_QUARTER: coin_val = Q_V;
      COIN_DIME:    coin_val = D_V;
      default:      coin_val = N_V;
    endcase
  end

  // Subtract is only requested after the matching >= compare, so no underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
    end else if (ld) begin
      rem <= amount;
    end else if (sub) begin
      rem <= rem - coin_val;
    end
  end

  assign ge_q     = (rem >= Q_V);
  assign ge_d     = (rem >= D_V);
  assign ge_n     = (rem >= N_V);
  assign rem_zero = (rem == '0);

endmodule

// File: rtl/vending_change_fsmd.sv
// Change-return FSMD: pays out a change amount one coin at a time, largest
// coin first, over a req/ack handshake with the coin hopper.
module vending_change_fsmd
  import vending_pkg::*;
#(
  parameter int W       = 8,
  parameter int QUARTER = DEF_QUARTER,
  parameter int DIME    = DEF_DIME,
  parameter int NICKEL  = DEF_NICKEL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] amount,
  output logic         coin_req,
  output logic [1:0]   coin_sel,
  input  logic         coin_ack,
  output logic         busy,
  output logic         done,
  output logic         short
);

  logic [1:0] state;
  logic [1:0] sel_r;
  logic       ld;
  logic       sub;
  logic       ge_q;
  logic       ge_d;
  logic       ge_n;
  logic       rem_zero;

  assign ld  = (state == CHG_IDLE) && start;
  assign sub = (state == CHG_REQ) && coin_ack;

  change_dp #(
    .W       (W),
    .QUARTER (QUARTER),
    .DIME    (DIME),
    .NICKEL  (NICKEL)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .sub      (sub),
    .sel      (sel_r),
    .amount   (amount),
    .ge_q     (ge_q),
    .ge_d     (ge_d),
    .ge_n     (ge_n),
    .rem_zero (rem_zero)
  );

  // Every ack returns through SEL, so there is no ack->req combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CHG_IDLE;
      sel_r <= COIN_NICKEL;
    end else begin
      case (state)
        CHG_IDLE: if (start) state <= CHG_SEL;
        CHG_SEL: begin
          if (ge_q) begin
            sel_r <= COIN_QUARTER;
            state <= CHG_REQ;
          end else if (ge_d) begin
            sel_r <= COIN_DIME;
            state <= CHG_REQ;
          end else if (ge_n) begin
            sel_r <= COIN_NICKEL;
            state <= CHG_REQ;
          end else begin
            state <= CHG_DONE;
          end
        end
        CHG_REQ:  if (coin_ack) state <= CHG_SEL;
        default:  state <= CHG_IDLE;
      endcase
    end
  end

  assign coin_req = (state == CHG_REQ);
  assign coin_sel = coin_req ? sel_r : COIN_NICKEL;
  assign busy     = (state != CHG_IDLE);
  assign done     = (state == CHG_DONE);
  assign short    = done && !rem_zero;

endmodule

// File: tb/tb_vending_change_fsmd.sv
// Scoreboard bench for vending_change_fsmd: stimulus pushes expected coins and
// done/short results; a monitor pops and compares as the DUT presents them.
module tb_vending_change_fsmd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       coin_ack;
  logic       busy;
  logic       done;
  logic       short;

  logic       hopper_ack = 1'b0;
  logic       stray_ack = 1'b0;
  int         ack_delay = 1;
  int         errors = 0;
  int         checks = 0;
  int         req_cycles = 0;

  logic [1:0] exp_coins[$];
  logic       exp_short[$];

  assign coin_ack = hopper_ack | stray_ack;

  always #5 clk = ~clk;

  vending_change_fsmd dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .amount   (amount),
    .coin_req (coin_req),
    .coin_sel (coin_sel),
    .coin_ack (coin_ack),
    .busy     (busy),
    .done     (done),
    .short    (short)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Hopper model: acks ack_delay cycles after coin_req rises, one-cycle ack.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (hopper_ack) begin
        hopper_ack = 1'b0;
        cnt = 0;
      end else if (coin_req) begin
        if (cnt >= ack_delay) begin
          hopper_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic       prev_req;
    logic [1:0] prev_sel;
    logic [1:0] ec;
    logic       es;
    prev_req = 1'b0;
    prev_sel = 2'd0;
    forever begin
      @(negedge clk);
      if (coin_req) begin
        req_cycles++;
        if (prev_req) checkOutput("coin_sel_stable", int'(coin_sel), int'(prev_sel));
      end
      if (coin_req && coin_ack) begin
        if (exp_coins.size() == 0) begin
          checkOutput("unexpected_coin", int'(coin_sel), 3);
        end else begin
          ec = exp_coins.pop_front();
          checkOutput("coin_sel", int'(coin_sel), int'(ec));
        end
      end
      if (done) begin
        if (exp_short.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          es = exp_short.pop_front();
          checkOutput("short", int'(short), int'(es));
          checkOutput("coins_left_at_done", exp_coins.size(), 0);
        end
      end else begin
        if (short) checkOutput("short_without_done", int'(short), 0);
      end
      prev_req = coin_req;
      prev_sel = coin_sel;
    end
  end

  task automatic applyStimulus(input logic [7:0] amt);
    @(posedge clk);
    #1;
    start = 1'b1;
    amount = amt;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) checkOutput({name, "_timeout"}, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({name, "_scoreboard_empty"}, exp_coins.size() + exp_short.size(), 0);
  endtask

  task automatic pushCoins(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) exp_coins.push_back(c);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_coin_req", int'(coin_req), 0);
    checkOutput("reset_coin_sel", int'(coin_sel), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_short", int'(short), 0);
    rst = 1'b0;

    // 40 cents: Q, D, N
    ack_delay = 1;
    req_cycles = 0;
    pushCoins(2'd2, 1); pushCoins(2'd1, 1); pushCoins(2'd0, 1);
    exp_short.push_back(1'b0);
    applyStimulus(8'd40);
    waitIdle("amt40");
    checkOutput("amt40_req_cycles", req_cycles, 6);

    // 0 cents: done two cycles after start, no request
    req_cycles = 0;
    exp_short.push_back(1'b0);
    applyStimulus(8'd0);
    checkOutput("amt0_busy_t1", int'(busy), 1);
    checkOutput("amt0_done_t1", int'(done), 0);
    @(posedge clk);
    #1;
    checkOutput("amt0_busy_t2", int'(busy), 1);
    checkOutput("amt0_done_t2", int'(done), 1);
    @(posedge clk);
    #1;
    checkOutput("amt0_busy_t3", int'(busy), 0);
    checkOutput("amt0_done_t3", int'(done), 0);
    waitIdle("amt0");
    checkOutput("amt0_req_cycles", req_cycles, 0);

    // 7 cents: single nickel, short residue; ack immediately with req
    ack_delay = 0;
    pushCoins(2'd0, 1);
    exp_short.push_back(1'b1);
    applyStimulus(8'd7);
    waitIdle("amt7");

    // 255 cents: 10 quarters then one nickel
    ack_delay = 1;
    pushCoins(2'd2, 10); pushCoins(2'd0, 1);
    exp_short.push_back(1'b0);
    applyStimulus(8'd255);
    waitIdle("amt255");

    // 6-cycle ack delay, single nickel: req held 7 cycles
    ack_delay = 6;
    req_cycles = 0;
    pushCoins(2'd0, 1);
    exp_short.push_back(1'b0);
    applyStimulus(8'd5);
    waitIdle("slow_ack");
    checkOutput("slow_ack_req_cycles", req_cycles, 7);

    // Stray ack while idle must not start anything
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    stray_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stray_ack_busy", int'(busy), 0);

    // Second start mid-payout is ignored
    ack_delay = 1;
    pushCoins(2'd2, 1); pushCoins(2'd1, 1); pushCoins(2'd0, 1);
    exp_short.push_back(1'b0);
    applyStimulus(8'd40);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    amount = 8'd99;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle("restart_ignored");

    // Reset while coin_req is high abandons the payout
    ack_delay = 50;
    pushCoins(2'd2, 1);
    exp_short.push_back(1'b0);
    applyStimulus(8'd40);
    begin
      int n;
      n = 0;
      while (!coin_req && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("rst_wait_req", int'(coin_req), 1);
    end
    rst = 1'b1;
    exp_coins.delete();
    exp_short.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_coin_req", int'(coin_req), 0);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_done", int'(done), 0);
    repeat (4) @(posedge clk);
    #1;

    // New payout after reset: 15 cents -> D, N
    ack_delay = 1;
    pushCoins(2'd1, 1); pushCoins(2'd0, 1);
    exp_short.push_back(1'b0);
    applyStimulus(8'd15);
    waitIdle("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
